dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port; the slave end of the dmem_addr/rmask/wmask/wdata → rdata/resp protocol.
- Backs requests with an internal word-addressed array and returns a one-cycle resp after a programmable latency.
- Used as the data-memory model in the CPU top-level bench and as the tightly-coupled data RAM in the digital top.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from request accept to resp; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dmem_addr  input  32  byte address. Bits [1:0] are ignored for indexing.
- dmem_rmask  input  4  byte read mask; nonzero means read request.
- dmem_wmask  input  4  byte write mask; nonzero means write request.
- dmem_wdata  input  32  write data; byte k = bits [8k+7:8k].
- dmem_rdata  output  32  read data; valid only while dmem_resp = 1.
- dmem_resp  output  1  single-cycle response strobe.
- dmem_err  output  1  misaligned-access flag, qualified by dmem_resp.

Behaviour:
- Request condition: (dmem_rmask | dmem_wmask) != 0, sampled at the rising edge.
- Reset: one clock, asynchronous active-high reset.
  - Asserting rst forces state IDLE, dmem_resp = 0, dmem_rdata = 0, dmem_err = 0, and counter = 0 immediately, without waiting for a clock edge.
  - Array contents are not reset.
  - A request in flight is abandoned with no resp. A write already committed remains.
- FSM states: IDLE, WAIT, RESP.
  - IDLE + request at edge: accept. Latch index, masks, and read word. Commit the write.
    - If LATENCY == 1, go to RESP.
    - Otherwise go to WAIT with counter = LATENCY-2.
  - WAIT: decrement counter. When counter == 0, go to RESP.
  - RESP: dmem_resp = 1 for exactly one cycle, then go to IDLE. Request inputs seen in RESP are the same transaction still held by the CPU and are ignored.
  - IDLE + no request: stay in IDLE.
- Latency: a request first presented in cycle T produces dmem_resp high in cycle T+LATENCY. Back-to-back requests are spaced by at least LATENCY+1 cycles.
- Requester holds its inputs until resp. The responder latches everything at accept, so later input changes have no effect on the transaction.
- Indexing: index = dmem_addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH×4 bytes.
- Write: for each k where wmask[k] = 1, mem[index] byte k <= wdata byte k. Unmasked bytes are unchanged.
- Read: dmem_rdata returns the full 32-bit word regardless of rmask; the CPU extracts bytes.
- Read and write together (both masks nonzero): read-before-write. rdata returns the word as it was before the write.
- dmem_rdata holds its last resp value when dmem_resp = 0. The bench may only check rdata with resp.
- Without the optional feature, dmem_err is tied to 0.

Optional Feature:
- Macro: DMEM_RESPONDER_ALIGN_CHECK_EN.
- When defined, each accepted request is checked for alignment. The active mask (wmask if nonzero, else rmask) must be one of:
  - 4'b1111 with addr[1:0] = 0;
  - 4'b0011 with addr[1:0] = 0;
  - 4'b1100 with addr[1:0] = 2;
  - 4'b0001<<k with addr[1:0] = k.
- On a violation:
  - the write is suppressed;
  - resp still occurs at T+LATENCY with dmem_err = 1 and dmem_rdata = 0.
- When undefined: no check is performed, every request is serviced, and dmem_err = 0.

Test Plan:
- Reset then write: wmask=4'hF, addr=0x10, wdata=0xDEADBEEF. Then read rmask=4'hF, addr=0x10 → each resp occurs exactly LATENCY cycles after its request; rdata = 0xDEADBEEF.
- Byte write: wmask=4'b0100, addr=0x12, wdata=0x00AA0000 over 0xDEADBEEF → a later read of 0x10 returns 0xDEAABEEF.
- Simultaneous read/write: rmask=4'hF, wmask=4'hF, addr=0x20, old word 0x11111111, wdata 0x22222222 → rdata = 0x11111111. A following read returns 0x22222222.
- Wrap, with DEPTH=1024: write 0xCAFEF00D to addr 0x0000_1004 → a read of addr 0x4 returns 0xCAFEF00D.
- Reset mid-transaction: assert rst in the WAIT state with LATENCY=4 → resp stays 0 and the FSM is in IDLE. A subsequent read completes normally with latency 4.
- With DMEM_RESPONDER_ALIGN_CHECK_EN: wmask=4'hF, addr=0x31 → resp with dmem_err = 1 and rdata = 0. A later read of 0x30 returns the unchanged prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side slave for the CPU data-memory port.
// A request is any nonzero rmask/wmask seen at a rising edge while IDLE.
// It is accepted on that edge and the write is committed on that edge.
// dmem_resp pulses for one cycle exactly LATENCY cycles after the request
// cycle, carrying the pre-write word on dmem_rdata.
// Handshake: the requester holds addr/masks/wdata until dmem_resp; the
// responder latches everything it needs at accept, so inputs seen in WAIT
// or RESP are ignored. dmem_rdata/dmem_err are meaningful only with
// dmem_resp and hold their last response value otherwise.
// Optional feature: define DMEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned
// accesses (write suppressed, dmem_err = 1, dmem_rdata = 0).
// DEPTH must be a power of two (>= 2); LATENCY must be within 1..15.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err
);

  localparam int AW = $clog2(DEPTH);
  // WAIT spans LATENCY-1 cycles: the counter runs LATENCY-2 down to 0.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_load_out;

  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_req;
  logic          w_accept;
  logic          w_err;
  logic          w_wr_en;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_resp_word;

  // Transaction captured at accept, and the registered response outputs.
  logic [31:0] r_word;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_err_out;

  // State as plain bits for external checkers.
  logic [1:0]  w_dbg_state;

  // Upper address bits wrap; the low two bits only matter to the align check.
  logic        w_unused;

  assign w_idx       = dmem_addr[AW+1:2];
  assign w_req       = |(dmem_rmask | dmem_wmask);
  assign w_accept    = (r_state == S_IDLE) && w_req;
  assign w_rd_word   = r_mem[w_idx];
  assign w_resp_word = w_err ? 32'h0 : w_rd_word;
  assign w_wr_en     = w_accept && !rst && (|dmem_wmask) && !w_err;
  assign w_dbg_state = r_state;
  assign w_unused    = &{1'b0, dmem_addr[31:AW+2], dmem_addr[1:0]};

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  logic [3:0] w_act_mask;

  // Alignment rule: the active mask must be a naturally aligned byte,
  // halfword or word lane set for the given low address bits.
  always_comb begin
    w_act_mask = (|dmem_wmask) ? dmem_wmask : dmem_rmask;
    w_err      = 1'b1;
    case (w_act_mask)
      4'b1111: w_err = (dmem_addr[1:0] != 2'd0);
      4'b0011: w_err = (dmem_addr[1:0] != 2'd0);
      4'b1100: w_err = (dmem_addr[1:0] != 2'd2);
      4'b0001: w_err = (dmem_addr[1:0] != 2'd0);
      4'b0010: w_err = (dmem_addr[1:0] != 2'd1);
      4'b0100: w_err = (dmem_addr[1:0] != 2'd2);
      4'b1000: w_err = (dmem_addr[1:0] != 2'd3);
      default: w_err = 1'b1;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  // Next-state and output-load decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
            w_load_out   = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_load_out   = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // FSM state, latched transaction and response registers; reset abandons
  // any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_word    <= 32'h0;
      r_err     <= 1'b0;
      r_rdata   <= 32'h0;
      r_err_out <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_word <= w_resp_word;
        r_err  <= w_err;
      end
      if (w_load_out) begin
        if (r_state == S_IDLE) begin
          r_rdata   <= w_resp_word;
          r_err_out <= w_err;
        end else begin
          r_rdata   <= r_word;
          r_err_out <= r_err;
        end
      end
    end
  end

  // Byte-masked write on accept; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (dmem_wmask[k]) r_mem[w_idx][8*k +: 8] <= dmem_wdata[8*k +: 8];
      end
    end
  end

  assign dmem_resp  = (r_state == S_RESP);
  assign dmem_rdata = r_rdata;
  assign dmem_err   = r_err_out;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder (DEPTH=1024, LATENCY=4).
// Expected {err, rdata} pairs are queued when a request is driven and
// popped when dmem_resp is observed.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic        clk;
  logic        rst;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;

  logic [32:0] exp_q[$];
  logic        chk_q[$];
  int          n_tests;
  int          n_fail;

  logic [31:0] model [8];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .dmem_err   (dmem_err)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    dmem_addr  = 32'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    dmem_wdata = 32'h0;
  endtask

  // Driver: present a request, wait (bounded) for resp, score it, and
  // confirm the resp strobe lasts one cycle. chk=0 skips the data compare
  // when the prior word is not yet known.
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic chk);
    int n;
    logic [32:0] e;
    logic        c;
    exp_q.push_back({exp_err, exp_rd});
    chk_q.push_back(chk);
    dmem_addr  = addr;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dmem_resp && n < 20);
    check({tag, ".latency"}, 33'(n), 33'(LAT));
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    check({tag, ".err"}, {32'h0, dmem_err}, {32'h0, e[32]});
    if (c) check({tag, ".rdata"}, {1'b0, dmem_rdata}, {1'b0, e[31:0]});
    idle_inputs();
    @(posedge clk);
    #1;
    check({tag, ".resp_one_cycle"}, {32'h0, dmem_resp}, 33'h0);
  endtask

  initial begin
    int quiet_bad;
    logic [3:0]  wm_tab [8];
    logic [1:0]  off_tab [8];
    n_tests = 0;
    n_fail  = 0;
    wm_tab  = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    off_tab = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset.resp",  {32'h0, dmem_resp}, 33'h0);
    check("reset.rdata", {1'b0, dmem_rdata}, 33'h0);
    check("reset.err",   {32'h0, dmem_err}, 33'h0);
    check("reset.state", {31'h0, dut.w_dbg_state}, 33'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word write then read back.
    do_txn("wr_word", 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    do_txn("rd_word", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Byte write: write-only resp still carries the old word.
    do_txn("wr_byte", 32'h12, 4'h0, 4'b0100, 32'h00AA0000, 32'hDEADBEEF, 1'b0, 1'b1);
    do_txn("rd_byte", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 1'b1);

    // Read-before-write on a combined request.
    do_txn("rw_init", 32'h20, 4'h0, 4'hF, 32'h11111111, 32'h0, 1'b0, 1'b0);
    do_txn("rw_both", 32'h20, 4'hF, 4'hF, 32'h22222222, 32'h11111111, 1'b0, 1'b1);
    do_txn("rw_after", 32'h20, 4'hF, 4'h0, 32'h0, 32'h22222222, 1'b0, 1'b1);

    // Address wrap modulo DEPTH*4 bytes.
    do_txn("wrap_wr", 32'h0000_1004, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    do_txn("wrap_rd", 32'h4, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

    // Reset during WAIT: no resp, FSM back to IDLE, committed write kept.
    dmem_addr  = 32'h40;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h12345678;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("midrst.in_wait", {31'h0, dut.w_dbg_state}, 33'h1);
    rst = 1'b1;
    #1;
    check("midrst.resp",  {32'h0, dmem_resp}, 33'h0);
    check("midrst.state", {31'h0, dut.w_dbg_state}, 33'h0);
    check("midrst.rdata", {1'b0, dmem_rdata}, 33'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    quiet_bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (dmem_resp !== 1'b0) quiet_bad++;
    end
    check("midrst.no_resp", 33'(quiet_bad), 33'h0);
    do_txn("midrst_rd", 32'h40, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b1);

    // Misaligned word write.
    do_txn("al_init", 32'h30, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    do_txn("al_bad", 32'h31, 4'h0, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b1);
    do_txn("al_rd", 32'h30, 4'hF, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
`else
    do_txn("al_bad", 32'h31, 4'h0, 4'hF, 32'h5A5A5A5A, 32'hA5A5A5A5, 1'b0, 1'b1);
    do_txn("al_rd", 32'h30, 4'hF, 4'h0, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b1);
`endif

    // Randomized aligned traffic over eight words against a byte model.
    for (int j = 0; j < 8; j++) begin
      model[j] = $urandom();
      do_txn("rnd_init", 32'h200 + 32'(4 * j), 4'h0, 4'hF, model[j], 32'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      int          j;
      int          p;
      logic [31:0] wd;
      logic [3:0]  rm;
      logic [31:0] old;
      j   = $urandom_range(0, 7);
      p   = $urandom_range(0, 7);
      wd  = $urandom();
      rm  = (wm_tab[p] == 4'h0 || $urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
      old = model[j];
      do_txn("rnd_op", 32'h200 + 32'(4 * j) + 32'(off_tab[p]), rm, wm_tab[p], wd,
             old, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
        if (wm_tab[p][k]) model[j][8*k +: 8] = wd[8*k +: 8];
      end
    end
    for (int j = 0; j < 8; j++) begin
      do_txn("rnd_final", 32'h200 + 32'(4 * j), 4'hF, 4'h0, 32'h0, model[j], 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
